add_num_operand_adder: RTL
==========================

Name: add_num_operand_adder

Overview:
- Compute stage of the add-numbers AFU.
- Sits between the CCI-P read-response capture and the write-request stage.
- Accepts one 512-bit cache line carrying a pair count and packed 8-bit operand pairs. Sums the pairs serially, one per cycle, then presents a 512-bit result line to the write stage with a valid/ready handshake.
- Keeps a running count of lines it has completed.

Parameters:
- OPERAND_W, 8, operand width in bits. Must be 8 in this revision: the byte-packed layout fixes it.
- MAX_PAIRS, 31, maximum pairs per line. Requires (1+2*MAX_PAIRS)*8 <= 512 and (1+MAX_PAIRS)*16 <= 512.
- LANE_W, 16, width of each result lane.

Ports:
- clk  in  1  AFU clock.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input line valid.
- in_ready  out  1  block can accept a line.
- in_data  in  512  line; byte0 = requested pair count n_req; a_i = byte[1+2i], b_i = byte[2+2i].
- out_valid  out  1  result line valid.
- out_ready  in  1  write stage accepts the result.
- out_data  out  512  result line; lane k = bits [16k+15:16k].
- busy  out  1  state != IDLE.
- lines_done  out  32  count of completed handshakes.

Interface decision: one clock; reset is synchronous and active-high; ports are named clk and reset.

Behaviour:
- Reset values: state=IDLE, in_ready=1, out_valid=0, out_data=0, busy=0, lines_done=0, internal idx=0.
- Reset mid-operation: the line in flight is dropped, with no output for it; reset values apply the next cycle.
- State IDLE: in_ready=1. When in_valid=1:
  - Capture in_data.
  - n = min(n_req, MAX_PAIRS). err = (n_req > MAX_PAIRS).
  - out_data cleared to 0.
  - lane0 = {err, n zero-extended to 15 bits}.
  - idx=0.
  - Next state is SUM if n>0, else HOLD.
- State SUM: in_ready=0. Each cycle:
  - lane[idx+1] = zero-extend(a_idx + b_idx), a 9-bit sum so no overflow is lost.
  - idx increments.
  - When idx == n-1 (the last pair), go to HOLD.
- State HOLD: out_valid=1; out_data held stable.
  - When out_ready=1: out_valid deasserts the next cycle, lines_done increments (wraps modulo 2^32), state goes to IDLE.
- Latency: line accepted at cycle T; out_valid rises at T+n+1 (T+1 when n=0).
- Minimum occupancy is n+2 cycles per line, since the IDLE state is re-entered before the next accept.
- Lanes n+1..31 are always 0.
- in_ready=0 in SUM and HOLD, so a line presented there is not accepted. Upstream must hold in_valid/in_data until in_ready.
- out_ready while out_valid=0 is ignored.
- out_ready held high before HOLD: the handshake completes in the first HOLD cycle.
- Simultaneous in_valid and out_ready in HOLD: only the output handshake occurs. The input is accepted in the following IDLE cycle.
- busy = (state != IDLE).

Decomposition:
- Shared package add_num_pkg holds:
  - constants OPERAND_W, MAX_PAIRS, LANE_W, LINE_W=512;
  - typedef t_add_state {IDLE, SUM, HOLD};
  - typedef t_result_lane (16 bits);
  - functions for operand byte offset and result lane offset.
- No sub-module: the per-cycle adder is a single expression. Keep everything in one module.

Test Plan:
- n_req=1, a0=20, b0=30, out_ready=1 -> out_valid at T+2; lane0=0x0001, lane1=50, other lanes 0; lines_done=1.
- n_req=3, pairs (255,255),(0,0),(100,27) -> out_valid at T+4; lane0=3, lane1=510, lane2=0, lane3=127.
- n_req=0 -> out_valid at T+1; out_data all zero; busy=0 after handshake.
- n_req=40 with all operands 1 -> lane0=0x801F; lanes1..31=2; out_valid at T+32.
- n_req=2 with out_ready low for 5 cycles, new in_valid held throughout -> out_data stable and in_ready=0 during HOLD; new line accepted one cycle after out_ready; lines_done increments once per handshake.
- reset asserted during SUM of an n=10 line -> next cycle state=IDLE, out_valid=0, lines_done unchanged; a subsequent n=1 line produces the correct result.

Source files
------------

// File: rtl/add_num_pkg.sv
// Shared constants, types and offset helpers for the add-numbers AFU compute stage.
package add_num_pkg;

  localparam int unsigned OPERAND_W = 8;
  localparam int unsigned MAX_PAIRS = 31;
  localparam int unsigned LANE_W    = 16;
  localparam int unsigned LINE_W    = 512;
  localparam int unsigned CNT_W     = 32;
  localparam int unsigned IDX_W     = $clog2(MAX_PAIRS + 1);
  localparam int unsigned OFF_W     = $clog2(LINE_W);
  localparam int unsigned SUM_W     = OPERAND_W + 1;
  localparam int unsigned LEN_W     = LANE_W - 1;
  localparam int unsigned USED_W    = (1 + 2 * MAX_PAIRS) * OPERAND_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUM  = 2'd1,
    HOLD = 2'd2
  } t_add_state;

  typedef logic [LANE_W-1:0] t_result_lane;

  // Bit offset of operand a (is_b=0) or b (is_b=1) of a pair; byte0 is the pair count.
  function automatic logic [OFF_W-1:0] operand_off(input logic [IDX_W-1:0] pair,
                                                   input logic is_b);
    return OFF_W'((32'd1 + 32'd2 * 32'(pair) + 32'(is_b)) * OPERAND_W);
  endfunction

  function automatic logic [OFF_W-1:0] lane_off(input logic [IDX_W-1:0] lane);
    return OFF_W'(32'(lane) * LANE_W);
  endfunction

endpackage

// File: rtl/add_num_operand_adder.sv
// Compute stage: captures one line of packed operand pairs, sums one pair per cycle,
// and offers the result line downstream with valid/ready.
module add_num_operand_adder
  import add_num_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [LINE_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [LINE_W-1:0] out_data,
  output logic              busy,
  output logic [CNT_W-1:0]  lines_done
);

  t_add_state        state, state_nxt;
  logic [LINE_W-1:0] line_q, line_nxt;
  logic [LINE_W-1:0] data_nxt;
  logic [IDX_W-1:0]  idx, idx_nxt;
  logic [IDX_W-1:0]  n_q, n_nxt;
  logic [CNT_W-1:0]  done_nxt;
  logic [7:0]        n_req;
  logic              err;
  logic [IDX_W-1:0]  n_sel;
  logic [SUM_W-1:0]  pair_sum;

  // Byte0 and the bytes past the last possible pair are never read from the captured line.
  logic unused_bits;
  assign unused_bits = ^{line_q[7:0], line_q[LINE_W-1:USED_W]};

  // Next-state, datapath and counter logic
  always_comb begin
    state_nxt = state;
    line_nxt  = line_q;
    data_nxt  = out_data;
    idx_nxt   = idx;
    n_nxt     = n_q;
    done_nxt  = lines_done;
    n_req     = in_data[7:0];
    err       = (n_req > 8'(MAX_PAIRS));
    n_sel     = err ? IDX_W'(MAX_PAIRS) : IDX_W'(n_req);
    pair_sum  = SUM_W'(line_q[operand_off(idx, 1'b0) +: OPERAND_W])
              + SUM_W'(line_q[operand_off(idx, 1'b1) +: OPERAND_W]);

    case (state)
      IDLE: begin
        if (in_valid) begin
          line_nxt              = in_data;
          n_nxt                 = n_sel;
          data_nxt              = '0;
          data_nxt[LANE_W-1:0]  = {err, LEN_W'(n_sel)};
          idx_nxt               = '0;
          state_nxt             = (n_sel != '0) ? SUM : HOLD;
        end
      end
      SUM: begin
        data_nxt[lane_off(IDX_W'(idx + IDX_W'(1))) +: LANE_W] = t_result_lane'(pair_sum);
        idx_nxt = IDX_W'(idx + IDX_W'(1));
        if (idx == IDX_W'(n_q - IDX_W'(1))) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          state_nxt = IDLE;
          done_nxt  = lines_done + CNT_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and registered outputs; handshake flags follow the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      line_q     <= '0;
      out_data   <= '0;
      idx        <= '0;
      n_q        <= '0;
      lines_done <= '0;
      in_ready   <= 1'b1;
      out_valid  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      line_q     <= line_nxt;
      out_data   <= data_nxt;
      idx        <= idx_nxt;
      n_q        <= n_nxt;
      lines_done <= done_nxt;
      in_ready   <= (state_nxt == IDLE);
      out_valid  <= (state_nxt == HOLD);
      busy       <= (state_nxt != IDLE);
    end
  end

endmodule
